// File: rtl/sw_pio_pkg.sv
// Shared types and constants for the switch PIO poller.
package sw_pio_pkg;

    localparam int unsigned PIO_DATA_W    = 8;
    localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        EVAL = 2'd3
    } poll_state_e;

endpackage

// File: rtl/sw_debounce.sv
// Debounce filter: tracks a candidate value over successive samples and
// commits it to the stable value once it has been seen enough times.
module sw_debounce
    import sw_pio_pkg::*;
#(
    parameter int unsigned DATA_W       = PIO_DATA_W,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eval,
    input  logic [DATA_W-1:0] sample,
    output logic              commit_c,
    output logic              event_c,
    output logic [DATA_W-1:0] commit_value_c,
    output logic [DATA_W-1:0] stable_value
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CNT);

    logic [DATA_W-1:0] cand_q, cand_d;
    logic [DATA_W-1:0] stable_q, stable_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              init_done_q, init_done_d;

    // Count uses the post-update value so a count of 1 commits on the first differing sample.
    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        init_done_d = init_done_q;
        commit_c    = 1'b0;
        event_c     = 1'b0;
        if (eval) begin
            if (sample == cand_q) begin
                if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                cand_d = sample;
                cnt_d  = 8'd1;
            end
            if (((cnt_d == CNT_MAX) && (cand_d != stable_q)) || !init_done_q) begin
                commit_c    = 1'b1;
                event_c     = init_done_q;
                stable_d    = cand_d;
                init_done_d = 1'b1;
            end
        end
    end

    assign commit_value_c = cand_d;
    assign stable_value   = stable_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_q      <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: rtl/sw_pio_poller.sv
// Avalon-MM read master that periodically polls the switch PIO, debounces
// the samples and raises rise/fall change events through a valid/ready port.
module sw_pio_poller
    import sw_pio_pkg::*;
#(
    parameter int unsigned DATA_W       = PIO_DATA_W,
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] stable_value,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_rise,
    output logic [DATA_W-1:0] evt_fall
);

    localparam int unsigned  CNT_W    = $clog2(POLL_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

    poll_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              read_q, read_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rise_q, rise_d;
    logic [DATA_W-1:0] fall_q, fall_d;
    logic              eval_c;
    logic              commit_c;
    logic              event_c;
    logic [DATA_W-1:0] commit_value_c;
    logic [DATA_W-1:0] stable_c;

    sw_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk            (clk),
        .reset_n        (reset_n),
        .eval           (eval_c),
        .sample         (sample_q),
        .commit_c       (commit_c),
        .event_c        (event_c),
        .commit_value_c (commit_value_c),
        .stable_value   (stable_c)
    );

    // Poll period is measured from READ entry, so the counter runs in every state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        read_d   = 1'b0;
        sample_d = sample_q;
        eval_c   = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (enable && (cnt_q == CNT_LAST)) begin
                    state_d = READ;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                end
            end
            READ: begin
                if (avm_waitrequest) begin
                    read_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                sample_d = avm_readdata;
                state_d  = EVAL;
            end
            EVAL: begin
                eval_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A transfer consumes the old deltas; a same-cycle commit loads only the new ones.
    always_comb begin
        rise_d  = rise_q;
        fall_d  = fall_q;
        valid_d = valid_q;
        if (valid_q && evt_ready) begin
            rise_d  = '0;
            fall_d  = '0;
            valid_d = 1'b0;
        end
        if (event_c) begin
            rise_d  = rise_d | (commit_value_c & ~stable_c);
            fall_d  = fall_d | (~commit_value_c & stable_c);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            read_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            read_q   <= read_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign avm_address  = PIO_DATA_ADDR;
    assign avm_read     = read_q;
    assign stable_value = stable_c;
    assign evt_valid    = valid_q;
    assign evt_rise     = rise_q;
    assign evt_fall     = fall_q;

endmodule
